// File: rtl/prog_loader.sv
// Framed byte-stream loader for the MiniRiscV instruction memory.
// Assembles big-endian words, pads with NOP, then releases the core.
module prog_loader #(
    parameter int          MEM_DEPTH   = 16,
    parameter int          INSTR_WIDTH = 16,
    parameter logic [15:0] NOP_WORD    = 16'hF000,
    parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_data,
    output logic                         imem_we,
    output logic [$clog2(MEM_DEPTH)-1:0] imem_addr,
    output logic [INSTR_WIDTH-1:0]       imem_wdata,
    output logic                         cpu_run,
    output logic                         busy,
    output logic                         err,
    output logic [$clog2(MEM_DEPTH):0]   words_loaded
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [8:0] MAXN = 9'(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE, COUNT, DATA_HI, DATA_LO, CHECK, FILL, RUN, ERR
    } state_t;

    state_t     state;
    logic [8:0] cnt;
    logic [8:0] waddr;
    logic [7:0] hi;
    logic [7:0] chk;
    logic       accept;

    assign in_ready = reset_n && (state != FILL);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == COUNT) || (state == DATA_HI) ||
                      (state == DATA_LO) || (state == CHECK) ||
                      (state == FILL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            waddr        <= '0;
            hi           <= '0;
            chk          <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_run      <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                IDLE, RUN, ERR: begin
                    cpu_run <= (state == RUN);
                    if (accept && in_data == HDR_BYTE) begin
                        state   <= COUNT;
                        err     <= 1'b0;
                        cpu_run <= 1'b0;
                    end
                end
                COUNT: if (accept) begin
                    if (in_data == 8'd0 || {1'b0, in_data} > MAXN) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        cnt   <= {1'b0, in_data};
                        waddr <= '0;
                        chk   <= in_data;
                        state <= DATA_HI;
                    end
                end
                DATA_HI: if (accept) begin
                    hi    <= in_data;
                    chk   <= chk ^ in_data;
                    state <= DATA_LO;
                end
                DATA_LO: if (accept) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= waddr[AW-1:0];
                    imem_wdata <= {hi, in_data};
                    chk        <= chk ^ in_data;
                    waddr      <= waddr + 9'd1;
                    state      <= (waddr + 9'd1 == cnt) ? CHECK : DATA_HI;
                end
                CHECK: if (accept) begin
                    if (in_data != chk) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        words_loaded <= cnt[CW-1:0];
                        // full image: last write already retired, run now
                        if (cnt == MAXN) begin
                            state   <= RUN;
                            cpu_run <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    imem_we    <= 1'b1;
                    imem_addr  <= waddr[AW-1:0];
                    imem_wdata <= NOP_WORD;
                    waddr      <= waddr + 9'd1;
                    if (waddr == MAXN - 9'd1) state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and random frames checked against
// a frame-level model of expected memory writes and run/err status.
module tb_prog_loader;

    localparam int D = 16;
    localparam logic [7:0] HDR = 8'hA5;

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_run;
    logic        busy;
    logic        err;
    logic [4:0]  words_loaded;

    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;
    logic [7:0] pl[$];
    bit   gaps = 0;
    int   wl_model = 0;
    logic [3:0] last_addr = '0;

    prog_loader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_run      (cpu_run),
        .busy         (busy),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every strobe must match the next expected write in order
    always @(negedge clk) begin
        if (reset_n) begin
            check("no_overlap", 32'(imem_we & cpu_run), 0);
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {28'd0, imem_addr}, 32'hFFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("waddr", 32'(imem_addr), 32'(mon_e.a));
                    check("wdata", 32'(imem_wdata), 32'(mon_e.d));
                end
                last_addr = imem_addr;
            end else begin
                check("addr_hold", 32'(imem_addr), 32'(last_addr));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit exp_we,
                             input bit allow_gap, input string tag);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_timeout"}, 32'(n < 100), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        check({tag, "_we"}, 32'(imem_we), 32'(exp_we));
        if (gaps && allow_gap)
            repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic rand_pl(input int n);
        pl.delete();
        repeat (2 * n) pl.push_back(8'($urandom));
    endtask

    task automatic send_frame(input logic [7:0] n, input bit bad);
        logic [7:0] c;
        int fill;
        send_byte(HDR, 1'b0, 1'b1, "hdr");
        check("hdr_busy", 32'(busy), 1);
        check("hdr_run", 32'(cpu_run), 0);
        check("hdr_err", 32'(err), 0);
        if (n == 8'd0 || int'(n) > D) begin
            send_byte(n, 1'b0, 1'b0, "badn");
            check("badn_err", 32'(err), 1);
            check("badn_busy", 32'(busy), 0);
            check("badn_run", 32'(cpu_run), 0);
            check("badn_wl", 32'(words_loaded), 32'(wl_model));
            return;
        end
        c = n;
        foreach (pl[i]) if (i < 2 * int'(n)) c ^= pl[i];
        for (int i = 0; i < int'(n); i++)
            exp_q.push_back('{a: 4'(i), d: {pl[2*i], pl[2*i+1]}});
        if (bad) c ^= 8'h07;
        else for (int a = int'(n); a < D; a++)
            exp_q.push_back('{a: 4'(a), d: 16'hF000});
        send_byte(n, 1'b0, 1'b1, "cnt");
        for (int i = 0; i < 2 * int'(n); i++)
            send_byte(pl[i], (i % 2) == 1, 1'b1, "data");
        send_byte(c, 1'b0, 1'b0, "chk");
        if (bad) begin
            check("badchk_err", 32'(err), 1);
            check("badchk_run", 32'(cpu_run), 0);
            check("badchk_busy", 32'(busy), 0);
            check("badchk_wl", 32'(words_loaded), 32'(wl_model));
            check("badchk_q", 32'(exp_q.size()), 0);
            return;
        end
        fill = D - int'(n);
        check("chk_ready", 32'(in_ready), 32'(fill == 0));
        check("chk_run", 32'(cpu_run), 32'(fill == 0));
        for (int k = 1; k <= fill; k++) begin
            @(negedge clk);
            check("fill_ready", 32'(in_ready), 32'(k == fill));
            check("fill_run", 32'(cpu_run), 0);
        end
        if (fill > 0) begin
            @(negedge clk);
            check("run_after_fill", 32'(cpu_run), 1);
        end
        wl_model = int'(n);
        check("ok_wl", 32'(words_loaded), 32'(wl_model));
        check("ok_err", 32'(err), 0);
        check("ok_busy", 32'(busy), 0);
        check("ok_q", 32'(exp_q.size()), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_we", 32'(imem_we), 0);
        check("rst_run", 32'(cpu_run), 0);
        check("rst_err", 32'(err), 0);
        check("rst_wl", 32'(words_loaded), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 1);
        check("idle_busy", 32'(busy), 0);

        pl = '{8'h05, 8'h12, 8'h45, 8'h53, 8'h15, 8'h54};
        send_frame(8'd3, 1'b0);
        send_frame(8'd3, 1'b1);
        send_frame(8'd3, 1'b0);

        send_frame(8'd0, 1'b0);
        send_frame(8'd17, 1'b0);
        rand_pl(16);
        send_frame(8'd16, 1'b0);

        gaps = 1;
        send_byte(8'h00, 1'b0, 1'b1, "garb0");
        send_byte(8'hFF, 1'b0, 1'b1, "garb1");
        check("garb_run", 32'(cpu_run), 1);
        check("garb_busy", 32'(busy), 0);
        pl = '{8'h05, 8'h12, 8'h45, 8'h53, 8'h15, 8'h54};
        send_frame(8'd3, 1'b0);

        gaps = 0;
        pl = '{8'h12, 8'h34};
        send_frame(8'd1, 1'b0);

        for (int it = 0; it < 8; it++) begin
            int n;
            n = $urandom_range(1, D);
            gaps = $urandom_range(0, 1) == 1;
            rand_pl(n);
            send_frame(8'(n), $urandom_range(0, 3) == 0);
        end

        gaps = 0;
        send_byte(HDR, 1'b0, 1'b0, "rhdr");
        send_byte(8'h03, 1'b0, 1'b0, "rcnt");
        send_byte(8'h05, 1'b0, 1'b0, "rhi");
        #2 reset_n = 1'b0;
        #1;
        check("arst_ready", 32'(in_ready), 0);
        check("arst_we", 32'(imem_we), 0);
        check("arst_addr", 32'(imem_addr), 0);
        check("arst_wdata", 32'(imem_wdata), 0);
        check("arst_run", 32'(cpu_run), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_err", 32'(err), 0);
        check("arst_wl", 32'(words_loaded), 0);
        last_addr = '0;
        wl_model = 0;
        repeat (3) begin
            @(negedge clk);
            check("arst_hold_we", 32'(imem_we), 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        rand_pl(5);
        send_frame(8'd5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader for the MiniRiscV core. It is the write side of the core's instruction memory.
- Receives a framed program over a valid/ready byte interface and assembles big-endian 16-bit instruction words.
- Writes each word into instruction memory, pads unused locations with NOP, then releases the CPU via cpu_run.
- Sits between the host/UART byte source and the core's instruction-memory write port. The core is held idle while cpu_run is low.

Parameters:
- MEM_DEPTH, 16, instruction memory depth in words (power of 2, 2..256).
- INSTR_WIDTH, 16, instruction width in bits; fixed to 16 (two bytes per word).
- NOP_WORD, 16'hF000, fill value written to unloaded locations.
- HDR_BYTE, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  byte source has data.
- in_ready  output  1  loader accepts the byte this cycle.
- in_data  input  8  stream byte.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  $clog2(MEM_DEPTH)  write address.
- imem_wdata  output  16  write data.
- cpu_run  output  1  high = core may execute; low = core held in reset.
- busy  output  1  frame in progress (any state other than IDLE/RUN/ERR).
- err  output  1  sticky frame error; cleared by the next HDR_BYTE.
- words_loaded  output  $clog2(MEM_DEPTH)+1  count of words in the last accepted frame.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, in_ready=0 while reset_n is low, imem_we=0, imem_addr=0, imem_wdata=0, cpu_run=0, busy=0, err=0, words_loaded=0. All cleared immediately, mid-frame included; memory contents are not touched.
- A byte transfers on a rising clk edge with in_valid&&in_ready. in_ready=1 in all states except FILL.
- Frame format: HDR_BYTE, N (word count), 2N data bytes (high byte first), CHK.
  - CHK = XOR of N and all 2N data bytes.
- State IDLE/RUN/ERR: accepted byte == HDR_BYTE -> COUNT, err<=0, cpu_run<=0 on the same edge. Any other byte is dropped and the state is held.
- State COUNT: N==0 or N>MEM_DEPTH -> ERR (err<=1). Otherwise latch N, set word address to 0, running checksum <= N, -> DATA_HI.
- State DATA_HI: latch the high byte, fold it into the checksum, -> DATA_LO.
- State DATA_LO: on accept, drive imem_we=1 next cycle with imem_addr=word address and imem_wdata={hi,lo}. Fold the byte into the checksum and increment the word address.
  - If the word address reaches N -> CHECK; else -> DATA_HI.
  - Write latency: strobe is registered, one cycle after the accepting edge, exactly one cycle wide.
- State CHECK: accepted byte != checksum -> ERR (err<=1, cpu_run stays 0, partial words stay in memory). Match -> words_loaded<=N.
  - Then FILL if N<MEM_DEPTH, else RUN.
- State FILL: in_ready=0. Write NOP_WORD, one word per cycle, to addresses N..MEM_DEPTH-1 (imem_we high each cycle), then -> RUN.
- State RUN: cpu_run=1 (registered, asserted on the cycle after the last write). A new HDR_BYTE drops cpu_run and restarts loading. No write ever overlaps cpu_run=1.
- HDR_BYTE appearing inside DATA/CHECK is treated as ordinary data; there is no resync.
- N==MEM_DEPTH: last address MEM_DEPTH-1. The address counter must not wrap, and there is no FILL.
- busy=1 in COUNT, DATA_HI, DATA_LO, CHECK, FILL.
- imem_addr holds its last value when imem_we=0.

Test Plan:
- Load 3 words: A5 03 05 12 45 53 15 54 43 -> writes 0x0512@0, 0x4553@1, 0x1554@2. Then 13 cycles of 0xF000 to addr 3..15, in_ready=0 during fill, then cpu_run=1, words_loaded=3, err=0.
- Bad checksum: same frame with CHK=44 -> three data writes occur, no fill, err=1, cpu_run=0, state ERR. A following correct frame clears err and reaches RUN.
- Count limits: A5 00 -> err=1. A5 11 (17 > 16) -> err=1. A5 10 + 32 bytes + correct CHK -> 16 writes, no fill, cpu_run=1 one cycle after the last write.
- Backpressure/gaps: random in_valid deassertion between bytes of the 3-word frame -> identical writes and timing relative to accepted bytes. Garbage bytes (00, FF) before A5 are ignored.
- Reload while running: in RUN send A5 -> cpu_run falls on that edge, busy=1. A new 1-word frame A5 01 12 34 27 -> write 0x1234@0, fill 1..15, cpu_run=1.
- Reset mid-frame: assert reset_n=0 after the DATA_HI byte -> outputs zero asynchronously with no further writes. After release, a complete frame loads normally.
